// File: rtl/ifu.sv
// -----------------------------------------------------------------------------
// ifu - instruction fetch unit
//
// Owns the fetch PC and issues in-order word requests to instruction memory
// (request/grant, responses return in grant order). Returned words land in a
// small prefetch FIFO whose head is presented to decode as {o_pc, o_inst}.
// Redirects from execute clear the FIFO and mark every in-flight request as
// stale so its response is dropped on arrival.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active low
//   o_im_req       fetch request valid
//   o_im_addr      word-aligned fetch address
//   i_im_gnt       request accepted when o_im_req & i_im_gnt
//   i_im_rvalid    response valid (grant order, >= 1 cycle after grant)
//   i_im_rdata     response instruction word
//   i_redirect     control-flow change
//   i_redirect_pc  new fetch target (bits [1:0] ignored)
//   i_stall        decode cannot accept this cycle
//   o_valid        o_pc/o_inst hold a real instruction
//   o_pc           PC of presented instruction (0 when invalid)
//   o_inst         presented instruction (NOP when invalid)
// -----------------------------------------------------------------------------
module ifu #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_im_req,
    output logic [31:0] o_im_addr,
    input  logic        i_im_gnt,
    input  logic        i_im_rvalid,
    input  logic [31:0] i_im_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    // One width for all counters; it covers outstanding + occupancy.
    localparam int CNT_W = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam int FA_W  = $clog2(FIFO_DEPTH);
    localparam int TA_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CNT_W-1:0] FIFO_DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAX_OUT_C    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TA_W-1:0]  TAG_LAST     = TA_W'(MAX_OUTSTANDING - 1);

    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic [CNT_W-1:0] outstanding_reg, outstanding_next;
    logic [CNT_W-1:0] occupancy_reg, occupancy_next;
    logic [CNT_W-1:0] discard_reg, discard_next;
    logic [TA_W-1:0]  tag_wr_ptr_reg, tag_rd_ptr_reg;
    logic [FA_W-1:0]  fifo_wr_ptr_reg, fifo_rd_ptr_reg;

    logic [31:0] tag_mem       [MAX_OUTSTANDING];
    logic [31:0] fifo_pc_mem   [FIFO_DEPTH];
    logic [31:0] fifo_inst_mem [FIFO_DEPTH];

    logic        grant;
    logic        rsp;
    logic        rsp_keep;
    logic        pop;
    logic [31:0] rsp_tag;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    function automatic logic [TA_W-1:0] tag_ptr_inc(input logic [TA_W-1:0] p);
        return (p == TAG_LAST) ? '0 : p + TA_W'(1);
    endfunction

    // Issue decision uses registered counts only. Since the counts can only
    // grow through a grant, an ungranted request never drops on its own and
    // its address (fetch_pc_reg) stays put until grant or redirect.
    // Gating with rst keeps every output quiet for the whole reset interval.
    assign o_im_req = rst
                    && (outstanding_reg < MAX_OUT_C)
                    && ((outstanding_reg + occupancy_reg) < FIFO_DEPTH_C)
                    && (discard_reg == '0);
    assign o_im_addr = fetch_pc_reg;

    assign grant    = o_im_req & i_im_gnt;
    // A response with nothing in flight is spurious and ignored entirely.
    assign rsp      = i_im_rvalid & (outstanding_reg != '0);
    assign rsp_keep = rsp & (discard_reg == '0) & ~i_redirect;
    assign rsp_tag  = tag_mem[tag_rd_ptr_reg];

    assign o_valid  = rst & (occupancy_reg != '0) & ~i_redirect;
    assign pop      = o_valid & ~i_stall;
    assign o_pc     = o_valid ? fifo_pc_mem[fifo_rd_ptr_reg]   : 32'h0;
    assign o_inst   = o_valid ? fifo_inst_mem[fifo_rd_ptr_reg] : NOP_INST;

    always_comb begin
        outstanding_next = outstanding_reg + CNT_W'(grant) - CNT_W'(rsp);
        fetch_pc_next    = fetch_pc_reg;
        occupancy_next   = occupancy_reg;
        discard_next     = discard_reg;

        if (grant) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
        if (rsp && (discard_reg != '0)) begin
            discard_next = discard_reg - CNT_W'(1);
        end
        if (rsp_keep && !pop) begin
            occupancy_next = occupancy_reg + CNT_W'(1);
        end else if (!rsp_keep && pop) begin
            occupancy_next = occupancy_reg - CNT_W'(1);
        end

        // Everything still in flight after this edge is stale, including a
        // request granted right now; a response consumed now is already
        // excluded from outstanding_next and is dropped via rsp_keep.
        if (i_redirect) begin
            fetch_pc_next  = {i_redirect_pc[31:2], 2'b00};
            occupancy_next = '0;
            discard_next   = outstanding_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_reg    <= {RESET_PC[31:2], 2'b00};
            outstanding_reg <= '0;
            occupancy_reg   <= '0;
            discard_reg     <= '0;
            tag_wr_ptr_reg  <= '0;
            tag_rd_ptr_reg  <= '0;
            fifo_wr_ptr_reg <= '0;
            fifo_rd_ptr_reg <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            outstanding_reg <= outstanding_next;
            occupancy_reg   <= occupancy_next;
            discard_reg     <= discard_next;

            // Tag queue tracks every in-flight request, stale or not.
            if (grant) begin
                tag_wr_ptr_reg <= tag_ptr_inc(tag_wr_ptr_reg);
            end
            if (rsp) begin
                tag_rd_ptr_reg <= tag_ptr_inc(tag_rd_ptr_reg);
            end

            if (i_redirect) begin
                fifo_wr_ptr_reg <= '0;
                fifo_rd_ptr_reg <= '0;
            end else begin
                if (rsp_keep) begin
                    fifo_wr_ptr_reg <= fifo_wr_ptr_reg + FA_W'(1);
                end
                if (pop) begin
                    fifo_rd_ptr_reg <= fifo_rd_ptr_reg + FA_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: contents are only observed through the
    // occupancy and outstanding counters.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[tag_wr_ptr_reg] <= fetch_pc_reg;
        end
        if (rsp_keep) begin
            fifo_pc_mem[fifo_wr_ptr_reg]   <= rsp_tag;
            fifo_inst_mem[fifo_wr_ptr_reg] <= i_im_rdata;
        end
    end

endmodule
